// File: rtl/btc_miner_pkg.sv
// Shared types and constants for the miner-side sweeper.
package btc_miner_pkg;

    localparam int unsigned TARGET_W = 256;
    localparam int unsigned NONCE_W  = 32;
    localparam int unsigned EXP_BASE = 3;
    localparam int unsigned EXP_MAX  = 32;

    typedef logic [TARGET_W-1:0] target_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_FINISH
    } state_t;

    // Expand a compact-bits word into a 256-bit target; bit 23 (sign) is ignored.
    function automatic target_t expand_target(input logic [31:0] cbits);
        logic [7:0] e;
        logic [5:0] d;
        logic [8:0] sh;
        target_t    m;
        target_t    t;
        e = cbits[31:24];
        m = TARGET_W'(cbits[22:0]);
        if (e > 8'(EXP_MAX)) begin
            d  = '0;
            sh = '0;
            t  = '1;
        end else if (e <= 8'(EXP_BASE)) begin
            d  = 6'(8'(EXP_BASE) - e);
            sh = {d, 3'b000};
            t  = m >> sh;
        end else begin
            d  = 6'(e - 8'(EXP_BASE));
            sh = {d, 3'b000};
            t  = m << sh;
        end
        return t;
    endfunction

endpackage

// File: rtl/btc_toggle_sync.sv
// Multi-flop synchroniser with edge detect, gated until the chain has flushed after reset.
module btc_toggle_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic pulse_c
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1) + 1;

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;
    logic                   armed;
    logic [CNT_W-1:0]       arm_cnt;

    // Synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            dly   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            dly   <= chain[SYNC_STAGES-1];
        end
    end

    // Arm edge detection once the chain and delay flop hold real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + CNT_W'(1);
            if (arm_cnt == CNT_W'(SYNC_STAGES)) begin
                armed <= 1'b1;
            end
        end
    end

    assign level   = chain[SYNC_STAGES-1];
    assign pulse_c = armed & (chain[SYNC_STAGES-1] ^ dly);

endmodule

// File: rtl/btc_nonce_sweeper.sv
// Sequences an external double-SHA-256 core over a nonce range and reports the first hit.
import btc_miner_pkg::*;

module btc_nonce_sweeper #(
    parameter int unsigned NONCE_STEP  = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         config_enable,
    input  logic         config_use_nonce_in,
    input  logic         config_oneshot,
    input  logic [31:0]  nonce_in,
    input  logic [31:0]  bits,
    output logic         hash_req,
    output logic [31:0]  hash_nonce,
    input  logic         hash_ack,
    input  logic [255:0] hash_digest,
    output logic [31:0]  nonce_a,
    output logic         nonce_found_a,
    output logic         done_a,
    output logic         busy
);

    state_t               state;
    target_t              target;
    target_t              digest;
    logic [NONCE_W-1:0]   nonce;
    logic                 oneshot_q;
    logic                 found_q;
    logic                 pending;
    logic                 fin_phase;

    logic                 start_pulse;
    logic                 start_level_unused;
    logic                 en_sync;
    logic                 en_edge_unused;

    logic [NONCE_W:0]     step_sum;
    logic                 found_c;
    logic                 pend_c;

    btc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (start),
        .level   (start_level_unused),
        .pulse_c (start_pulse)
    );

    btc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enable_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (config_enable),
        .level   (en_sync),
        .pulse_c (en_edge_unused)
    );

    // Digest compare, next-nonce arithmetic and restart request seen in CHECK.
    always_comb begin
        step_sum = {1'b0, nonce} + (NONCE_W + 1)'(NONCE_STEP);
        found_c  = (digest <= target);
        pend_c   = pending | start_pulse;
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            target        <= '0;
            digest        <= '0;
            nonce         <= '0;
            oneshot_q     <= 1'b0;
            found_q       <= 1'b0;
            pending       <= 1'b0;
            fin_phase     <= 1'b0;
            hash_req      <= 1'b0;
            hash_nonce    <= '0;
            nonce_a       <= '0;
            nonce_found_a <= 1'b0;
            done_a        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pending <= 1'b0;
                    if (start_pulse && en_sync) begin
                        state         <= ST_ARM;
                        busy          <= 1'b1;
                        done_a        <= 1'b0;
                        nonce_found_a <= 1'b0;
                    end
                end

                ST_ARM: begin
                    target    <= expand_target(bits);
                    nonce     <= config_use_nonce_in ? nonce_in : '0;
                    oneshot_q <= config_oneshot;
                    pending   <= start_pulse;
                    state     <= ST_REQ;
                end

                ST_REQ: begin
                    hash_req   <= 1'b1;
                    hash_nonce <= nonce;
                    if (start_pulse) begin
                        pending <= 1'b1;
                    end
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (start_pulse) begin
                        pending <= 1'b1;
                    end
                    if (hash_req && hash_ack) begin
                        hash_req <= 1'b0;
                        digest   <= hash_digest;
                        state    <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (found_c) begin
                        found_q   <= 1'b1;
                        pending   <= 1'b0;
                        fin_phase <= 1'b0;
                        state     <= ST_FINISH;
                    end else if (oneshot_q || !en_sync) begin
                        found_q   <= 1'b0;
                        pending   <= 1'b0;
                        fin_phase <= 1'b0;
                        state     <= ST_FINISH;
                    end else if (pend_c) begin
                        pending <= 1'b0;
                        state   <= ST_ARM;
                    end else if (step_sum[NONCE_W]) begin
                        found_q   <= 1'b0;
                        fin_phase <= 1'b0;
                        state     <= ST_FINISH;
                    end else begin
                        nonce <= step_sum[NONCE_W-1:0];
                        state <= ST_REQ;
                    end
                end

                ST_FINISH: begin
                    pending <= 1'b0;
                    if (!fin_phase) begin
                        nonce_a       <= nonce;
                        nonce_found_a <= found_q;
                        fin_phase     <= 1'b1;
                    end else begin
                        fin_phase <= 1'b0;
                        done_a    <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btc_nonce_sweeper.sv
// Directed and randomized bench for btc_nonce_sweeper with a behavioural hash-core responder.
module tb_btc_nonce_sweeper;

    localparam int unsigned NONCE_STEP  = 1;
    localparam int unsigned SYNC_STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         config_enable;
    logic         config_use_nonce_in;
    logic         config_oneshot;
    logic [31:0]  nonce_in;
    logic [31:0]  bits;
    logic         hash_req;
    logic [31:0]  hash_nonce;
    logic         hash_ack;
    logic [255:0] hash_digest;
    logic [31:0]  nonce_a;
    logic         nonce_found_a;
    logic         done_a;
    logic         busy;

    btc_nonce_sweeper #(.NONCE_STEP(NONCE_STEP), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .config_enable       (config_enable),
        .config_use_nonce_in (config_use_nonce_in),
        .config_oneshot      (config_oneshot),
        .nonce_in            (nonce_in),
        .bits                (bits),
        .hash_req            (hash_req),
        .hash_nonce          (hash_nonce),
        .hash_ack            (hash_ack),
        .hash_digest         (hash_digest),
        .nonce_a             (nonce_a),
        .nonce_found_a       (nonce_found_a),
        .done_a              (done_a),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Hash-core personality
    bit           dg_const;
    logic [255:0] const_digest;
    bit           pass_en;
    logic [31:0]  pass_nonce;
    logic [255:0] pass_digest;
    logic [255:0] fail_base;
    logic [31:0]  hold_nonce;
    bit           hold_armed = 1'b0;

    logic [31:0]  req_q[$];
    logic [31:0]  exp_q[$];
    int           ack_cyc;
    int           fin_cyc;
    logic [31:0]  prev_nonce_a;
    int           done_rises = 0;
    logic [31:0]  exp_nonce_a;
    logic         exp_found;

    function automatic logic [255:0] ref_target(input logic [31:0] b);
        int           e;
        logic [255:0] t;
        e = int'(b[31:24]);
        t = 256'(b[22:0]);
        if (e > 32) return {256{1'b1}};
        if (e <= 3) begin
            for (int i = e; i < 3; i++) t = t / 256;
            return t;
        end
        for (int i = 3; i < e; i++) t = t * 256;
        return t;
    endfunction

    function automatic logic [255:0] digest_for(input logic [31:0] n);
        if (dg_const) return const_digest;
        if (pass_en && n == pass_nonce) return pass_digest;
        return fail_base + 256'(n[7:0]);
    endfunction

    // Reference sweep: walk nonces upward until hit, oneshot, or the 32-bit range ends.
    task automatic model_run(input logic [31:0] s, input bit oneshot, input logic [255:0] tgt);
        longint n;
        exp_q.delete();
        exp_found = 1'b0;
        n = longint'(s);
        forever begin
            exp_q.push_back(n[31:0]);
            exp_nonce_a = n[31:0];
            if (digest_for(n[31:0]) <= tgt) begin
                exp_found = 1'b1;
                break;
            end
            if (oneshot || n == 64'h0000_0000_FFFF_FFFF) break;
            n = n + longint'(NONCE_STEP);
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reqs(input string tag);
        int n;
        check({tag, " req_count"}, 256'(req_q.size()), 256'(exp_q.size()));
        n = (req_q.size() < exp_q.size()) ? req_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s req[%0d]", tag, i), 256'(req_q[i]), 256'(exp_q[i]));
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen_busy;
        bit ok;
        seen_busy = busy;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            if (seen_busy && done_a && !busy) begin
                ok = 1'b1;
                break;
            end
            prev_nonce_a = nonce_a;
        end
        fin_cyc = cyc;
        check({tag, " run_completes"}, 256'(ok), 256'(1));
    endtask

    task automatic wait_req(input string tag, input logic [31:0] n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (hash_req && hash_nonce == n) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " req_seen"}, 256'(ok), 256'(1));
    endtask

    task automatic do_run(input string tag);
        req_q.delete();
        start = ~start;
        wait_done(tag, 2000);
    endtask

    // Behavioural hash core: random latency, one-cycle ack, optional long hold on one nonce.
    initial begin : responder
        int lat;
        bit lat_set;
        hash_ack    = 1'b0;
        hash_digest = '0;
        lat         = 0;
        lat_set     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hash_ack = 1'b0;
                lat_set  = 1'b0;
            end else if (hash_ack) begin
                hash_ack = 1'b0;
            end else if (hash_req === 1'b1) begin
                if (!lat_set) begin
                    if (hold_armed && hash_nonce == hold_nonce) begin
                        lat        = 20;
                        hold_armed = 1'b0;
                    end else begin
                        lat = int'($urandom_range(0, 3));
                    end
                    lat_set = 1'b1;
                end
                if (lat == 0) begin
                    hash_digest = digest_for(hash_nonce);
                    hash_ack    = 1'b1;
                    req_q.push_back(hash_nonce);
                    ack_cyc     = cyc;
                    lat_set     = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Count rising edges of done_a to catch spurious pulses between chained runs.
    initial begin : done_mon
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1 && done_prev !== 1'b1) done_rises++;
            done_prev = done_a;
        end
    end

    initial begin : stim
        logic [255:0] tgt;
        logic [31:0]  s;
        logic [7:0]   e;
        int           rises0;
        bit           held;

        rst_n               = 1'b0;
        start               = 1'b0;
        config_enable       = 1'b1;
        config_use_nonce_in = 1'b0;
        config_oneshot      = 1'b0;
        nonce_in            = '0;
        bits                = '0;
        dg_const            = 1'b0;
        const_digest        = '0;
        pass_en             = 1'b0;
        pass_nonce          = '0;
        pass_digest         = '0;
        fail_base           = '1;
        hold_nonce          = '0;

        repeat (3) @(negedge clk);
        check("reset hash_req", 256'(hash_req), 256'(0));
        check("reset busy", 256'(busy), 256'(0));
        check("reset done_a", 256'(done_a), 256'(0));
        check("reset nonce_a", 256'(nonce_a), 256'(0));
        check("reset found", 256'(nonce_found_a), 256'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Four-request sweep with a hit at 0x103.
        bits = 32'h1d00ffff; nonce_in = 32'h100; config_use_nonce_in = 1'b1;
        tgt = ref_target(bits);
        pass_en = 1'b1; pass_nonce = 32'h103; pass_digest = '0; fail_base = tgt + 256'(1);
        model_run(32'h100, 1'b0, tgt);
        do_run("sweep");
        check_reqs("sweep");
        check("sweep nonce_a", 256'(nonce_a), 256'(32'h103));
        check("sweep found", 256'(nonce_found_a), 256'(1));
        check("sweep done_latency", 256'(fin_cyc - ack_cyc), 256'(4));
        check("sweep nonce_a_before_done", 256'(prev_nonce_a), 256'(32'h103));

        // Oneshot with exponent 3 (hit) then exponent 2 (miss).
        config_oneshot = 1'b1; config_use_nonce_in = 1'b0;
        dg_const = 1'b1; const_digest = 256'h123456;
        bits = 32'h03123456;
        check("exp3 target", ref_target(bits), 256'h123456);
        model_run(32'h0, 1'b1, ref_target(bits));
        do_run("oneshot_e3");
        check_reqs("oneshot_e3");
        check("oneshot_e3 found", 256'(nonce_found_a), 256'(exp_found));
        check("oneshot_e3 nonce_a", 256'(nonce_a), 256'(0));
        bits = 32'h02123456;
        model_run(32'h0, 1'b1, ref_target(bits));
        do_run("oneshot_e2");
        check_reqs("oneshot_e2");
        check("oneshot_e2 found", 256'(nonce_found_a), 256'(exp_found));
        check("oneshot_e2 done", 256'(done_a), 256'(1));

        // Range exhaustion at the top of the 32-bit space.
        config_oneshot = 1'b0; dg_const = 1'b0; config_use_nonce_in = 1'b1;
        nonce_in = 32'hFFFF_FFFE; bits = 32'h1d00ffff; tgt = ref_target(bits);
        pass_en = 1'b0; fail_base = tgt + 256'(1);
        model_run(nonce_in, 1'b0, tgt);
        do_run("wrap");
        check_reqs("wrap");
        check("wrap nonce_a", 256'(nonce_a), 256'(32'hFFFF_FFFF));
        check("wrap found", 256'(nonce_found_a), 256'(0));
        check("wrap done", 256'(done_a), 256'(1));

        // Enable dropped while nonce 5 is outstanding.
        config_use_nonce_in = 1'b0;
        hold_nonce = 32'd5; hold_armed = 1'b1;
        req_q.delete();
        start = ~start;
        wait_req("en_drop", 32'd5, 500);
        config_enable = 1'b0;
        held = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (hash_req !== 1'b1) held = 1'b0;
        end
        check("en_drop req_held", 256'(held), 256'(1));
        wait_done("en_drop", 500);
        exp_q.delete();
        for (int i = 0; i <= 5; i++) exp_q.push_back(32'(i));
        check_reqs("en_drop");
        check("en_drop nonce_a", 256'(nonce_a), 256'(5));
        check("en_drop found", 256'(nonce_found_a), 256'(0));
        config_enable = 1'b1;
        repeat (6) @(negedge clk);

        // Restart toggle while 0x41 is outstanding: run reloads from 0x40.
        config_use_nonce_in = 1'b1; nonce_in = 32'h40;
        pass_en = 1'b1; pass_nonce = 32'h42; pass_digest = '0; fail_base = tgt + 256'(1);
        hold_nonce = 32'h41; hold_armed = 1'b1;
        rises0 = done_rises;
        req_q.delete();
        start = ~start;
        wait_req("restart", 32'h41, 500);
        repeat (2) @(negedge clk);
        start = ~start;
        wait_done("restart", 1000);
        exp_q.delete();
        exp_q.push_back(32'h40); exp_q.push_back(32'h41);
        exp_q.push_back(32'h40); exp_q.push_back(32'h41); exp_q.push_back(32'h42);
        check_reqs("restart");
        check("restart done_rises", 256'(done_rises - rises0), 256'(1));
        check("restart nonce_a", 256'(nonce_a), 256'(32'h42));
        check("restart found", 256'(nonce_found_a), 256'(1));
        repeat (6) @(negedge clk);

        // Randomized targets, start points and hit positions (hit digest equals target).
        for (int it = 0; it < 5; it++) begin
            e = 8'($urandom_range(0, 34));
            bits = {e, 24'($urandom)};
            nonce_in = $urandom_range(0, 32'hFFFF_0000);
            config_use_nonce_in = 1'($urandom_range(0, 1));
            s = config_use_nonce_in ? nonce_in : 32'h0;
            tgt = ref_target(bits);
            pass_en = 1'b1; pass_nonce = s + 32'($urandom_range(0, 4));
            pass_digest = tgt; fail_base = tgt + 256'(1);
            model_run(s, 1'b0, tgt);
            do_run($sformatf("rand%0d", it));
            check_reqs($sformatf("rand%0d", it));
            check($sformatf("rand%0d nonce_a", it), 256'(nonce_a), 256'(exp_nonce_a));
            check($sformatf("rand%0d found", it), 256'(nonce_found_a), 256'(exp_found));
        end

        // start held high through reset release must not launch a run.
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; config_enable = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        req_q.delete();
        repeat (20) @(negedge clk);
        check("rst_hi busy", 256'(busy), 256'(0));
        check("rst_hi reqs", 256'(req_q.size()), 256'(0));
        check("rst_hi done", 256'(done_a), 256'(0));
        config_oneshot = 1'b1; config_use_nonce_in = 1'b0;
        dg_const = 1'b1; const_digest = '0; bits = 32'h1d00ffff;
        model_run(32'h0, 1'b1, ref_target(bits));
        do_run("rst_hi_run");
        check_reqs("rst_hi_run");
        check("rst_hi_run found", 256'(nonce_found_a), 256'(1));
        check("rst_hi_run nonce_a", 256'(nonce_a), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin : watchdog
        #800000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/btc_nonce_sweeper.md
Name: btc_nonce_sweeper

Overview:
- Miner-side control stage directly downstream of the Wishbone miner register block.
- Consumes the register block's start toggle, config bits, nonce_in and bits fields, and sequences an external double-SHA-256 hash core over a nonce range.
- Compares each digest against the compact-bits target and returns nonce_a / nonce_found_a / done_a to the register block, which synchronises done_a.
- Runs in the miner clock domain, which is asynchronous to the Wishbone clock.

Parameters:
- NONCE_STEP, 1: nonce increment per hash; lets parallel sweepers interleave.
- SYNC_STAGES, 2: synchroniser depth for start and config_enable, minimum 2.

Ports:
- clk  in  1  miner clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  toggle from the register block; any edge is a start request (Wishbone domain)
- config_enable  in  1  run permission (Wishbone domain)
- config_use_nonce_in  in  1  1 = first nonce is nonce_in, 0 = first nonce is 0; quasi-static
- config_oneshot  in  1  stop after exactly one hash; quasi-static
- nonce_in  in  32  start nonce; quasi-static
- bits  in  32  compact target; quasi-static
- hash_req  out  1  request to the hash core
- hash_nonce  out  32  nonce for the current request
- hash_ack  in  1  one-cycle pulse: digest valid
- hash_digest  in  256  final hash as an unsigned integer, MSB = most significant byte
- nonce_a  out  32  result nonce
- nonce_found_a  out  1  1 = digest <= target
- done_a  out  1  level; 0 while a run is active, 1 when the run has ended
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, synchroniser chains 0, armed = 0.
- CDC:
  - start and config_enable each pass through a SYNC_STAGES flop chain.
  - An edge is detected between the last sync stage and one further delay flop.
  - armed sets SYNC_STAGES+1 cycles after reset release; edges are ignored while armed = 0, so no spurious start is seen if start is already 1 at reset release.
- Quasi-static inputs are sampled only in ARM; software keeps them stable while busy.
- IDLE:
  - On a start edge with synced enable = 1: go to ARM, done_a <= 0, nonce_found_a <= 0.
  - On a start edge with enable = 0: ignore it; outputs unchanged.
- ARM, 1 cycle:
  - Latch target from bits; latch nonce = use_nonce_in ? nonce_in : 0. Go to REQ.
  - Target expansion: e = bits[31:24], m = {bits[22:0]} (bit 23 ignored).
  - e <= 3: target = m >> 8*(3-e).
  - 4 <= e <= 32: target = m << 8*(e-3), truncated to 256 bits.
  - e > 32: target = all ones.
- REQ: hash_req = 1, hash_nonce = nonce. hash_req is held until hash_ack. Go to WAIT.
- WAIT: on hash_ack, drop hash_req in the same cycle it is sampled, register the digest, go to CHECK.
  - hash_ack while hash_req = 0 is ignored.
- CHECK, 1 cycle:
  - found = digest <= target (256-bit unsigned compare); {carry, next} = nonce + NONCE_STEP.
  - Priority order:
    1. found → FINISH(found = 1).
    2. oneshot → FINISH(found = 0).
    3. synced enable = 0 → FINISH(found = 0).
    4. pending restart → ARM.
    5. carry → FINISH(found = 0), range exhausted.
    6. Otherwise nonce <= next, go to REQ.
- FINISH (DONE state):
  - Cycle 1: nonce_a <= last tried nonce, nonce_found_a <= found.
  - Cycle 2: done_a <= 1, go to IDLE.
  - Data is therefore stable at least 1 cycle before done_a rises and held until the next start.
- Start edge while busy:
  - Sets pending restart; it never aborts an outstanding hash request.
  - Serviced in CHECK, where it clears and reloads ARM. done_a stays 0.
- Enable deassert while busy: the current hash completes, then the run stops (found is still reported if it occurred).
- Reset mid-run: hash_req drops immediately. The hash core must tolerate a request withdrawn by reset.

Decomposition:
- Shared package btc_miner_pkg: state enum (IDLE, ARM, REQ, WAIT, CHECK, FINISH), the 256-bit target type, and the compact-target exponent constants (3, 32).
- Sub-module btc_toggle_sync: parameterised SYNC_STAGES synchroniser with edge detect and armed gating. Instantiated for start; its level output is used for config_enable.

Test Plan:
- bits = 0x1d00ffff, nonce_in = 0x100, use_nonce_in = 1; core digests > target for 0x100..0x102, digest 0 at 0x103 → four requests, nonce_a = 0x103, nonce_found_a = 1, done_a rises 2 cycles after the 0x103 CHECK.
- bits = 0x03123456 and 0x02123456, oneshot = 1, digest = 0x123456 → found = 1 (target 0x123456), then found = 0 (target 0x1234).
- use_nonce_in = 1, nonce_in = 0xFFFFFFFE, NONCE_STEP = 1, digests never pass → exactly 2 requests, nonce_a = 0xFFFFFFFF, found = 0, done_a = 1.
- Enable deasserted during WAIT for nonce 5 → hash_req stays high until ack, no nonce 6 request, nonce_a = 5, done_a = 1.
- Start toggles during WAIT → after ack, a new ARM, nonce restarts at its initial value, done_a never pulses high between runs.
- Start = 1 held through reset release with enable = 1 → no run (busy = 0); a later toggle 1→0 starts one run.
